// File: rtl/cpu_step_ctrl.sv
// Turns raw step/run buttons into a single-cycle CPU clock enable, in STEP or RUN mode.
// Buttons are synchronised and debounced, and clk_en is registered; step_count counts issued enables.
module cpu_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int RUN_DIV         = 1000000,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             btn_step,
   input  logic             btn_run,
   output logic             clk_en,
   output logic             run_mode,
   output logic [CNT_W-1:0] step_count
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DIV_W = $clog2(RUN_DIV);
   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

   typedef enum logic {
      ST_STEP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Bit 0 is the step button, bit 1 the run button.
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      stable;
   logic [1:0]      stable_d;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      press;
   logic            step_press;
   logic            run_press;

   state_t           state;
   state_t           state_nxt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_nxt;
   logic             clk_en_q;
   logic             clk_en_nxt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1    <= {btn_run, btn_step};
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign press      = stable & ~stable_d;
   assign step_press = press[0];
   assign run_press  = press[1];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= ST_STEP;
         div      <= '0;
         clk_en_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         div      <= div_nxt;
         clk_en_q <= clk_en_nxt;
      end
   end

   // A run press always wins: it discards a coincident step press and kills a pending RUN pulse.
   always_comb begin
      state_nxt  = state;
      div_nxt    = div;
      clk_en_nxt = 1'b0;
      case (state)
         ST_STEP: begin
            if (run_press) begin
               state_nxt = ST_RUN;
               div_nxt   = '0;
            end else if (step_press) begin
               clk_en_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (run_press) begin
               state_nxt = ST_STEP;
               div_nxt   = '0;
            end else if (div == DIV_MAX) begin
               div_nxt    = '0;
               clk_en_nxt = 1'b1;
            end else begin
               div_nxt = div + DIV_W'(1);
            end
         end
         default: begin
            state_nxt = ST_STEP;
            div_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         step_count <= '0;
      end else if (clk_en_q) begin
         step_count <= step_count + CNT_W'(1);
      end
   end

   // The CPU keeps getting clock edges while held in reset.
   assign clk_en   = clk_en_q | ~resetn;
   assign run_mode = (state == ST_RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomised bench for cpu_step_ctrl: a raw-button reference model predicts every clk_en pulse
// into a scoreboard that a cycle monitor drains, plus a few directed end-to-end checks.
module tb_cpu_step_ctrl;

   localparam int D  = 4;
   localparam int RD = 5;
   localparam int CW = 8;

   logic          clk      = 1'b0;
   logic          resetn   = 1'b0;
   logic          btn_step = 1'b0;
   logic          btn_run  = 1'b0;
   logic          clk_en;
   logic          run_mode;
   logic [CW-1:0] step_count;

   always #5 clk = ~clk;

   cpu_step_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .RUN_DIV        (RD),
      .CNT_W          (CW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .btn_step  (btn_step),
      .btn_run   (btn_run),
      .clk_en    (clk_en),
      .run_mode  (run_mode),
      .step_count(step_count)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int last_pulse_cyc = -1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model, working directly on the raw button samples: a level is accepted once it
   // has been seen on D+1 consecutive samples, and a press becomes visible 3 cycles later.
   typedef struct { int t; int cnt; } pulse_t;
   typedef struct { int t; bit stp; bit rn; } evt_t;
   pulse_t sbq[$];
   evt_t   evq[$];
   bit     m_stable [2];
   int     m_run    [2];
   bit     m_mode;
   int     m_next;
   int     m_cnt;

   always @(posedge clk) begin
      bit   raw;
      bit   ev [2];
      bit   rev;
      bit   sev;
      evt_t e;
      cyc++;
      if (!resetn) begin
         for (int b = 0; b < 2; b++) begin
            m_stable[b] = 1'b0;
            m_run[b]    = 0;
         end
         m_mode = 1'b0;
         m_next = 0;
         m_cnt  = 0;
         evq.delete();
         sbq.delete();
      end else begin
         for (int b = 0; b < 2; b++) begin
            raw   = (b == 0) ? btn_step : btn_run;
            ev[b] = 1'b0;
            if (raw != m_stable[b]) begin
               m_run[b]++;
               if (m_run[b] == D + 1) begin
                  m_stable[b] = raw;
                  m_run[b]    = 0;
                  ev[b]       = raw;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         if (ev[0] || ev[1]) evq.push_back('{cyc + 3, ev[0], ev[1]});
         rev = 1'b0;
         sev = 1'b0;
         if (evq.size() > 0 && evq[0].t == cyc) begin
            e   = evq.pop_front();
            rev = e.rn;
            sev = e.stp;
         end
         if (rev) begin
            m_mode = !m_mode;
            m_next = cyc + RD;
         end else if (m_mode && cyc == m_next) begin
            sbq.push_back('{cyc, m_cnt});
            m_cnt  = (m_cnt + 1) % 256;
            m_next = m_next + RD;
         end else if (!m_mode && sev) begin
            sbq.push_back('{cyc, m_cnt});
            m_cnt = (m_cnt + 1) % 256;
         end
      end
   end

   always @(posedge clk) begin
      pulse_t p;
      #2;
      if (!resetn) begin
         chk("reset_clk_en", int'(clk_en), 1);
         chk("reset_run_mode", int'(run_mode), 0);
         chk("reset_step_count", int'(step_count), 0);
      end else begin
         chk("run_mode", int'(run_mode), int'(m_mode));
         if (clk_en) last_pulse_cyc = cyc;
         if (sbq.size() > 0 && sbq[0].t == cyc) begin
            p = sbq.pop_front();
            chk("pulse_present", int'(clk_en), 1);
            chk("count_at_pulse", int'(step_count), p.cnt);
         end else begin
            chk("no_pulse", int'(clk_en), 0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int which, input int hold, input int rel);
      @(negedge clk);
      if (which == 0) btn_step = 1'b1; else btn_run = 1'b1;
      idle(hold);
      if (which == 0) btn_step = 1'b0; else btn_run = 1'b0;
      idle(rel);
   endtask

   initial begin
      int c0;
      int s0;
      bit seen;

      // Reset for three edges, then quiet.
      resetn = 1'b0;
      idle(3);
      resetn = 1'b1;
      idle(100);

      // Long press: single pulse 7 cycles after the first sampling edge (= drive cycle + 8).
      @(negedge clk);
      c0 = cyc;
      btn_step = 1'b1;
      idle(20);
      btn_step = 1'b0;
      idle(20);
      chk("long_press_latency", last_pulse_cyc - c0, 8);
      chk("long_press_count", int'(step_count), 1);

      // Bounce 1/0/1/0 in 2-cycle segments, then a steady press.
      @(negedge clk);
      btn_step = 1'b1; idle(2);
      btn_step = 1'b0; idle(2);
      btn_step = 1'b1; idle(2);
      btn_step = 1'b0; idle(2);
      c0 = cyc;
      btn_step = 1'b1;
      idle(12);
      btn_step = 1'b0;
      idle(12);
      chk("bounce_latency", last_pulse_cyc - c0, 8);
      chk("bounce_count", int'(step_count), 2);

      // Too-short press (one sample under the threshold) then minimum-length presses.
      press(0, D, 10);
      press(0, D + 1, D + 1);
      for (int i = 0; i < 6; i++) press(0, $urandom_range(D + 1, D + 5), $urandom_range(D + 1, D + 5));

      // Enter RUN: exactly 10 enables in any 50-cycle window.
      press(1, $urandom_range(D + 1, D + 5), $urandom_range(D + 1, D + 5));
      idle(10);
      chk("run_entered", int'(run_mode), 1);
      s0 = int'(step_count);
      idle(50);
      chk("run_rate", (int'(step_count) - s0) & 255, 10);
      press(0, $urandom_range(D + 1, D + 5), $urandom_range(D + 1, D + 5));
      idle($urandom_range(0, 7));

      // Leave RUN, then a coincident step+run press from STEP.
      press(1, $urandom_range(D + 1, D + 5), $urandom_range(D + 1, D + 5));
      idle(20);
      chk("run_left", int'(run_mode), 0);
      @(negedge clk);
      btn_step = 1'b1;
      btn_run  = 1'b1;
      idle(8);
      btn_step = 1'b0;
      btn_run  = 1'b0;
      idle(10);
      chk("coincident_mode", int'(run_mode), 1);

      // Reset in RUN when the divider is at 3 (three cycles after a pulse).
      seen = 1'b0;
      for (int i = 0; i < 3 * RD && !seen; i++) begin
         @(posedge clk);
         #2;
         if (clk_en) seen = 1'b1;
      end
      chk("run_pulse_seen", int'(seen), 1);
      idle(4);
      resetn = 1'b0;
      #1;
      chk("reset_comb_clk_en", int'(clk_en), 1);
      idle(3);
      resetn = 1'b1;
      idle(2);
      chk("post_reset_clk_en", int'(clk_en), 0);
      chk("post_reset_mode", int'(run_mode), 0);
      chk("post_reset_count", int'(step_count), 0);

      // Wrap of step_count after 256 presses.
      for (int i = 0; i < 255; i++) press(0, $urandom_range(D + 1, D + 5), $urandom_range(D + 1, D + 5));
      idle(5);
      chk("count_255", int'(step_count), 255);
      press(0, D + 3, D + 3);
      idle(5);
      chk("count_wrap", int'(step_count), 0);

      idle(20);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
